clock_input_ctrl: RTL and testbench

- Front end of the digital clock. Runs on the 100 MHz system clock.
- Divides the system clock down to produce `tick_1Hz`.
- Synchronises and debounces the three raw set buttons. Each press becomes a clean single-cycle `inc_sec`/`inc_min`/`inc_hour` pulse, with auto-repeat while the button is held.
- Outputs drive the time-keeping stage directly.
- Guarantees that no increment pulse ever lands in the same cycle as a tick.

---
 rtl/clock_input_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_clock_input_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_input_ctrl.sv
// Clock front end: 1 Hz divider plus synchronised, debounced,
// auto-repeating set buttons. Increment pulses never share a cycle with a tick.
module clock_input_ctrl #(
  parameter int unsigned DIV_COUNT       = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 100_000_000,
  parameter int unsigned REPEAT_PERIOD   = 25_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       run,
  input  logic       btn_sec,
  input  logic       btn_min,
  input  logic       btn_hour,
  output logic       tick_1Hz,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       inc_hour,
  output logic [2:0] btn_held
);

  localparam int unsigned DIV_W =
    (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int unsigned DEB_W =
    $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                   : REPEAT_PERIOD;
  localparam int unsigned REP_W =
    (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(DIV_COUNT - 1);
  localparam logic [DEB_W-1:0] DEB_MAX =
    DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [REP_W-1:0] DELAY_LAST =
    REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST =
    REP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } rep_state_t;

  logic [DIV_W-1:0] div_cnt;
  logic             tick_next;

  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] stable;
  logic [2:0] req;
  logic [2:0] pending;
  logic [2:0] want;
  logic [2:0] inc_q;

  assign tick_next = run && (div_cnt == DIV_LAST);

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (!run || tick_next) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign raw = {btn_hour, btn_min, btn_sec};

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_btn
    logic [DEB_W-1:0] deb_cnt;
    logic             stable_r;
    logic [REP_W-1:0] rep_cnt;
    rep_state_t       state;
    logic             req_b;

    assign stable[i] = stable_r;
    assign req[i]    = req_b;

    // a full count adopts whatever the synced level is now
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
        deb_cnt  <= '0;
        stable_r <= 1'b0;
      end else if (deb_cnt == DEB_MAX) begin
        deb_cnt  <= '0;
        stable_r <= sync2[i];
      end else if (sync2[i] != stable_r) begin
        deb_cnt  <= deb_cnt + DEB_W'(1);
      end else begin
        deb_cnt  <= '0;
      end
    end

    always_comb begin
      req_b = 1'b0;
      unique case (state)
        IDLE:    req_b = stable_r;
        HOLD:    req_b = stable_r && (rep_cnt == DELAY_LAST);
        REPEAT:  req_b = stable_r && (rep_cnt == PERIOD_LAST);
        default: req_b = 1'b0;
      endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
        state   <= IDLE;
        rep_cnt <= '0;
      end else if (!stable_r) begin
        state   <= IDLE;
        rep_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state   <= HOLD;
            rep_cnt <= '0;
          end
          HOLD: begin
            if (rep_cnt == DELAY_LAST) begin
              state   <= REPEAT;
              rep_cnt <= '0;
            end else begin
              rep_cnt <= rep_cnt + REP_W'(1);
            end
          end
          REPEAT: begin
            if (rep_cnt == PERIOD_LAST) begin
              rep_cnt <= '0;
            end else begin
              rep_cnt <= rep_cnt + REP_W'(1);
            end
          end
          default: begin
            state   <= IDLE;
            rep_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign want = req | pending;

  // a tick cycle defers requests by one cycle via the pending flags
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      tick_1Hz <= 1'b0;
      inc_q    <= '0;
      pending  <= '0;
    end else begin
      tick_1Hz <= tick_next;
      if (tick_next) begin
        inc_q   <= '0;
        pending <= want;
      end else begin
        inc_q   <= want;
        pending <= '0;
      end
    end
  end

  assign inc_sec  = inc_q[0];
  assign inc_min  = inc_q[1];
  assign inc_hour = inc_q[2];
  assign btn_held = stable;

endmodule

// File: tb/tb_clock_input_ctrl.sv
// Directed bench for clock_input_ctrl with small parameters
// (DIV 10, debounce 4, repeat delay 20, period 5).
module tb_clock_input_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       run;
  logic       btn_sec;
  logic       btn_min;
  logic       btn_hour;
  logic       tick_1Hz;
  logic       inc_sec;
  logic       inc_min;
  logic       inc_hour;
  logic [2:0] btn_held;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int overlap = 0;
  int q_tick[$];
  int q_sec[$];
  int q_min[$];
  int q_hour[$];

  clock_input_ctrl #(
    .DIV_COUNT(10),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk_100MHz(clk),
    .reset_n(reset_n),
    .run(run),
    .btn_sec(btn_sec),
    .btn_min(btn_min),
    .btn_hour(btn_hour),
    .tick_1Hz(tick_1Hz),
    .inc_sec(inc_sec),
    .inc_min(inc_min),
    .inc_hour(inc_hour),
    .btn_held(btn_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // cycle n = value launched by edge n, seen at the following negedge
  always @(negedge clk) begin
    if (tick_1Hz) q_tick.push_back(cyc);
    if (inc_sec) q_sec.push_back(cyc);
    if (inc_min) q_min.push_back(cyc);
    if (inc_hour) q_hour.push_back(cyc);
    if (tick_1Hz && (inc_sec || inc_min || inc_hour))
      overlap++;
  end

  task automatic chk(input string tag, input int got,
                     input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, got, exp);
    end
  endtask

  task automatic chkq(input string tag, input int got[$],
                      input int exp[$]);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s[%0d]", tag, i),
          (i < got.size()) ? got[i] : -1, exp[i]);
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample_at(input int n);
    goto(n);
    @(negedge clk);
  endtask

  initial begin
    int e_tick[$];
    int e_sec[$];
    int e_min[$];
    int e_hour[$];

    reset_n  = 1'b0;
    run      = 1'b1;
    btn_sec  = 1'b0;
    btn_min  = 1'b1;
    btn_hour = 1'b0;

    sample_at(2);
    chk("rst_tick", int'(tick_1Hz), 0);
    chk("rst_inc", int'({inc_hour, inc_min, inc_sec}), 0);
    chk("rst_held", int'(btn_held), 0);

    goto(3);
    reset_n = 1'b1;
    btn_min = 1'b0;

    sample_at(12);
    chk("tick_c12", int'(tick_1Hz), 0);
    sample_at(13);
    chk("tick_c13", int'(tick_1Hz), 1);
    sample_at(14);
    chk("tick_c14", int'(tick_1Hz), 0);
    sample_at(23);
    chk("tick_c23", int'(tick_1Hz), 1);
    goto(28);
    run = 1'b0;
    sample_at(33);
    chk("tick_stopped", int'(tick_1Hz), 0);
    goto(43);
    run = 1'b1;
    sample_at(53);
    chk("tick_rerun", int'(tick_1Hz), 1);
    goto(58);
    run = 1'b0;

    goto(70);
    btn_min = 1'b1;
    sample_at(76);
    chk("min_held_pre", int'(btn_held[1]), 0);
    sample_at(77);
    chk("min_held_rise", int'(btn_held[1]), 1);
    sample_at(78);
    chk("min_pulse", int'(inc_min), 1);
    goto(82);
    btn_min = 1'b0;
    sample_at(88);
    chk("min_held_still", int'(btn_held[1]), 1);
    sample_at(89);
    chk("min_held_fall", int'(btn_held[1]), 0);

    goto(130);
    btn_sec = 1'b1;
    goto(133);
    btn_sec = 1'b0;
    goto(136);
    btn_sec = 1'b1;
    sample_at(137);
    chk("bounce_held_a", int'(btn_held[0]), 0);
    goto(139);
    btn_sec = 1'b0;
    goto(142);
    btn_sec = 1'b1;
    goto(145);
    btn_sec = 1'b0;
    sample_at(147);
    chk("bounce_held_b", int'(btn_held[0]), 0);
    sample_at(160);
    chk("bounce_held_c", int'(btn_held[0]), 0);

    goto(180);
    btn_hour = 1'b1;
    sample_at(208);
    chk("hour_rep1", int'(inc_hour), 1);
    goto(230);
    btn_hour = 1'b0;
    sample_at(233);
    chk("hour_rep_last", int'(inc_hour), 1);
    sample_at(236);
    chk("hour_held_pre", int'(btn_held[2]), 1);
    sample_at(237);
    chk("hour_held_fall", int'(btn_held[2]), 0);
    sample_at(238);
    chk("hour_no_rep", int'(inc_hour), 0);

    goto(260);
    run = 1'b1;
    goto(272);
    btn_sec = 1'b1;
    sample_at(280);
    chk("coll_tick", int'(tick_1Hz), 1);
    chk("coll_sec_held", int'(inc_sec), 0);
    sample_at(281);
    chk("coll_tick_after", int'(tick_1Hz), 0);
    chk("coll_sec_late", int'(inc_sec), 1);
    goto(282);
    btn_sec = 1'b0;

    goto(300);
    btn_min  = 1'b1;
    btn_hour = 1'b1;
    sample_at(308);
    chk("dual_min", int'(inc_min), 1);
    chk("dual_hour", int'(inc_hour), 1);
    goto(310);
    btn_min  = 1'b0;
    btn_hour = 1'b0;
    goto(312);
    run = 1'b0;

    goto(340);
    btn_hour = 1'b1;
    sample_at(378);
    chk("pre_rst_pulse", int'(inc_hour), 1);
    chk("pre_rst_held", int'(btn_held), 4);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_inc", int'({inc_hour, inc_min, inc_sec}), 0);
    chk("async_held", int'(btn_held), 0);
    chk("async_tick", int'(tick_1Hz), 0);
    goto(381);
    reset_n = 1'b1;
    sample_at(387);
    chk("post_rst_held0", int'(btn_held[2]), 0);
    sample_at(388);
    chk("post_rst_held1", int'(btn_held[2]), 1);
    chk("post_rst_early", int'(inc_hour), 0);
    sample_at(389);
    chk("post_rst_pulse", int'(inc_hour), 1);
    goto(415);
    btn_hour = 1'b0;

    goto(440);
    e_tick = '{13, 23, 53, 270, 280, 290, 300, 310};
    e_sec  = '{281};
    e_min  = '{78, 308};
    e_hour = '{188, 208, 213, 218, 223, 228, 233,
               308, 348, 368, 373, 378,
               389, 409, 414, 419};
    chkq("ticks", q_tick, e_tick);
    chkq("sec", q_sec, e_sec);
    chkq("min", q_min, e_min);
    chkq("hour", q_hour, e_hour);
    chk("no_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
